// File: rtl/video_fetch.sv
// video_fetch: 1-bpp raster fetch and shift engine.
// Reads one video-memory byte per 8 pixel clocks. Each byte goes first into
// a hold register and then into a shift register. The top bit of the shift
// register is presented as the luminance pixel inside the active window.
//
// Ports:
//   clk                 pixel clock, one pixel per rising edge
//   rst                 asynchronous active-low reset
//   cntHS, cntVS        horizontal / vertical counters from the sync generator
//   HS_start, HS_end    active columns [HS_start, HS_end)
//   VS_start, VS_end    active lines   [VS_start, VS_end)
//   frame_addr          frame base address, sampled once per frame
//   VAD                 video memory address (registered)
//   VDI                 video memory data, valid one clock after VAD changes
//   pixel               luminance bit
//   active              combinational active-window flag
module video_fetch #(
  parameter int BYTES_PER_LINE = 40,   // must be <= 64 (the fetch span fits in 9 bits)
  parameter bit INVERT         = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [8:0]  cntHS,
  input  logic [8:0]  cntVS,
  input  logic [8:0]  HS_start,
  input  logic [8:0]  HS_end,
  input  logic [8:0]  VS_start,
  input  logic [8:0]  VS_end,
  input  logic [15:0] frame_addr,
  output logic [15:0] VAD,
  input  logic [7:0]  VDI,
  output logic        pixel,
  output logic        active
);

  localparam logic [6:0]  NBYTES = 7'(BYTES_PER_LINE);
  localparam logic [15:0] STRIDE = 16'(BYTES_PER_LINE);

  logic [15:0] line_addr_q, line_addr_d;
  logic [15:0] fetch_addr_q, fetch_addr_d;
  logic [7:0]  hold_q, hold_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  vmask_q, vmask_d;   // marks which shift bits still hold fetched data
  logic        frame_valid_q, frame_valid_d;

  logic       vline, hact;
  logic [8:0] fofs, sofs;
  logic       frame_go, line_adv, fetch_ld, cap, shl;

  assign vline  = (cntVS >= VS_start) && (cntVS < VS_end);
  assign hact   = (cntHS >= HS_start) && (cntHS < HS_end);
  assign active = vline && hact;

  // fofs counts from the fetch-window origin F = HS_start - 8.
  // sofs counts from one column before HS_start, which is where shift loads.
  // Both use 9-bit modulo arithmetic. Columns before the origin wrap to
  // large values and drop out of the range tests below. This keeps the
  // schedule stateless, so a backward jump of cntHS cannot leave it
  // half-way through a line.
  assign fofs = cntHS - (HS_start - 9'd8);
  assign sofs = cntHS - HS_start + 9'd1;

  assign frame_go = (cntVS == VS_start) && (cntHS == 9'd0);
  assign line_adv = vline && (cntHS == HS_end);
  assign fetch_ld = vline && (fofs == 9'h1FF);
  assign cap      = vline && (fofs[2:0] == 3'd1) && ({1'b0, fofs[8:3]} < NBYTES);
  assign shl      = vline && (sofs[2:0] == 3'd0) && ({1'b0, sofs[8:3]} < NBYTES);

  always_comb begin
    line_addr_d   = line_addr_q;
    frame_valid_d = frame_valid_q;
    if (frame_go) begin
      line_addr_d   = frame_addr;
      frame_valid_d = 1'b1;
    end else if (line_adv) begin
      line_addr_d   = line_addr_q + STRIDE;
    end
  end

  always_comb begin
    fetch_addr_d = fetch_addr_q;
    hold_d       = hold_q;
    if (fetch_ld) begin
      fetch_addr_d = line_addr_q;
    end else if (cap) begin
      fetch_addr_d = fetch_addr_q + 16'd1;
      hold_d       = VDI;
    end
  end

  always_comb begin
    shift_d = {shift_q[6:0], 1'b0};
    vmask_d = {vmask_q[6:0], 1'b0};
    if (shl) begin
      shift_d = hold_q;
      vmask_d = 8'hFF;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_addr_q   <= 16'h0000;
      fetch_addr_q  <= 16'h0000;
      hold_q        <= 8'h00;
      shift_q       <= 8'h00;
      vmask_q       <= 8'h00;
      frame_valid_q <= 1'b0;
    end else begin
      line_addr_q   <= line_addr_d;
      fetch_addr_q  <= fetch_addr_d;
      hold_q        <= hold_d;
      shift_q       <= shift_d;
      vmask_q       <= vmask_d;
      frame_valid_q <= frame_valid_d;
    end
  end

  assign VAD = fetch_addr_q;

  // Once the last byte has shifted out, vmask is empty and the pixel is
  // forced to 0 even when INVERT is set.
  assign pixel = active && frame_valid_q && vmask_q[7] && (shift_q[7] ^ INVERT);

endmodule
